// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: pin sync, clock glitch filter, 11-bit frame FSM
// with odd-parity/stop checking and a watchdog for truncated frames.
module ps2_scancode_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       CLOCK_50,
  input  logic       Resetn,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] received_data,
  output logic       received_data_en,
  output logic       parity_err,
  output logic       frame_err
);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [16:0] WD_LAST = 17'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
  logic [FILTER_LEN-1:0]  hist_q, hist_d;
  logic                   fclk_q, fclk_d;
  logic                   fall_q, fall_d;

  state_t      state_q, state_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic [16:0] wd_q, wd_d;
  logic [16:0] wd_inc;
  logic [7:0]  data_q, data_d;
  logic        en_q, en_d;
  logic        perr_q, perr_d;
  logic        ferr_q, ferr_d;

  logic clk_s;
  logic dat_s;
  logic busy;
  logic timeout;
  logic par_ok;

  assign clk_s = clk_sync_q[SYNC_STAGES-1];
  assign dat_s = dat_sync_q[SYNC_STAGES-1];

  always_comb begin
    clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], PS2_CLK};
    dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], PS2_DAT};
    hist_d     = {hist_q[FILTER_LEN-2:0], clk_s};
    fclk_d     = fclk_q;
    if (&hist_q) begin
      fclk_d = 1'b1;
    end else if (hist_q == '0) begin
      fclk_d = 1'b0;
    end
    fall_d = fclk_q & ~fclk_d;
  end

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      hist_q     <= '1;
      fclk_q     <= 1'b1;
      fall_q     <= 1'b0;
      state_q    <= IDLE;
      bit_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      wd_q       <= '0;
      data_q     <= '0;
      en_q       <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      hist_q     <= hist_d;
      fclk_q     <= fclk_d;
      fall_q     <= fall_d;
      state_q    <= state_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      wd_q       <= wd_d;
      data_q     <= data_d;
      en_q       <= en_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
    end
  end

  // A fall in the timeout cycle wins, so the abort is gated by !fall_q.
  assign busy    = (state_q != IDLE);
  assign wd_inc  = wd_q + 17'd1;
  assign timeout = busy && !fall_q && (wd_inc == WD_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fall_q && !dat_s) state_d = DATA;
      DATA:    if (fall_q && bit_q == 3'd7) state_d = PARITY;
      PARITY:  if (fall_q) state_d = STOP;
      STOP:    if (fall_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (timeout) state_d = IDLE;
  end

  assign par_ok = ^{shift_q, par_q};

  always_comb begin
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    data_d  = data_q;
    en_d    = 1'b0;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    // wd_q counts cycles since the last accepted fall
    if (state_d == IDLE) begin
      wd_d = '0;
    end else if (fall_q) begin
      wd_d = 17'd1;
    end else begin
      wd_d = wd_inc;
    end
    case (state_q)
      IDLE: begin
        bit_d = '0;
      end
      DATA: begin
        if (fall_q) begin
          shift_d = {dat_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
        end
      end
      PARITY: begin
        if (fall_q) par_d = dat_s;
      end
      STOP: begin
        if (fall_q) begin
          unique case (1'b1)
            !dat_s: ferr_d = 1'b1;
            dat_s && par_ok: begin
              data_d = shift_q;
              en_d   = 1'b1;
            end
            dat_s && !par_ok: perr_d = 1'b1;
          endcase
        end
      end
      default: ;
    endcase
    if (timeout) begin
      ferr_d  = 1'b1;
      bit_d   = '0;
      shift_d = '0;
    end
  end

  assign received_data    = data_q;
  assign received_data_en = en_q;
  assign parity_err       = perr_q;
  assign frame_err        = ferr_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Scoreboard bench for ps2_scancode_rx: frames are driven on the pins,
// expected pulses are queued with their due cycle and matched on output.
module tb_ps2_scancode_rx;

  localparam int TO  = 1000;
  localparam int H   = 150;
  localparam int LAT = 12;

  localparam logic [2:0] K_EN   = 3'b100;
  localparam logic [2:0] K_PERR = 3'b010;
  localparam logic [2:0] K_FERR = 3'b001;

  logic       CLOCK_50 = 1'b0;
  logic       Resetn   = 1'b0;
  logic       PS2_CLK  = 1'b1;
  logic       PS2_DAT  = 1'b1;
  logic [7:0] received_data;
  logic       received_data_en;
  logic       parity_err;
  logic       frame_err;

  typedef struct {
    logic [2:0] kind;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  ps2_scancode_rx #(
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLOCK_50        (CLOCK_50),
    .Resetn          (Resetn),
    .PS2_CLK         (PS2_CLK),
    .PS2_DAT         (PS2_DAT),
    .received_data   (received_data),
    .received_data_en(received_data_en),
    .parity_err      (parity_err),
    .frame_err       (frame_err)
  );

  initial forever #10 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  always @(negedge CLOCK_50) begin
    if (Resetn && (received_data_en || parity_err || frame_err)) begin
      check("one_hot",
            $countones({received_data_en, parity_err, frame_err}), 1);
      if (sb.size() == 0) begin
        check("spurious_pulse",
              {29'd0, received_data_en, parity_err, frame_err}, 0);
      end else begin
        mon_e = sb.pop_front();
        check("pulse_kind",
              {29'd0, received_data_en, parity_err, frame_err},
              {29'd0, mon_e.kind});
        check("pulse_cycle", cyc, mon_e.cyc);
        if (mon_e.kind == K_EN)
          check("rx_data", {24'd0, received_data}, {24'd0, mon_e.data});
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic drive_bit(input bit b, input bit glitch,
                           input bit push, input logic [2:0] kind,
                           input logic [7:0] d, input int lat);
    exp_t e;
    @(negedge CLOCK_50);
    PS2_DAT = b;
    if (glitch) begin
      wait_cycles(40);
      PS2_CLK = 1'b0;
      wait_cycles(5);
      PS2_CLK = 1'b1;
      wait_cycles(H - 45);
    end else begin
      wait_cycles(H - 1);
    end
    PS2_CLK = 1'b0;
    if (push) begin
      e.kind = kind;
      e.data = d;
      e.cyc  = cyc + lat;
      sb.push_back(e);
    end
    wait_cycles(H);
    PS2_CLK = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit pflip,
                            input bit stopb, input int nbits,
                            input int gbit);
    logic [10:0] bits;
    logic [2:0]  kind;
    int          lat;
    bits = {stopb, (~^d) ^ pflip, d, 1'b0};
    if (nbits == 11) begin
      lat  = LAT;
      kind = !stopb ? K_FERR : (pflip ? K_PERR : K_EN);
    end else begin
      lat  = LAT - 2 + TO;
      kind = K_FERR;
    end
    for (int i = 0; i < nbits; i++)
      drive_bit(bits[i], gbit == i, i == nbits - 1, kind, d, lat);
    PS2_DAT = 1'b1;
    wait_cycles(300);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 3 * TO) begin
      @(negedge CLOCK_50);
      t++;
    end
    check("drain_pending", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    wait_cycles(5);
    check("rst_data", {24'd0, received_data}, 0);
    check("rst_en", {31'd0, received_data_en}, 0);
    check("rst_perr", {31'd0, parity_err}, 0);
    check("rst_ferr", {31'd0, frame_err}, 0);
    Resetn = 1'b1;
    wait_cycles(20);

    send_frame(8'h1C, 1'b0, 1'b1, 11, -1);
    drain();
    check("hold_1C", {24'd0, received_data}, 32'h1C);

    send_frame(8'hF0, 1'b0, 1'b1, 11, -1);
    send_frame(8'h23, 1'b0, 1'b1, 11, -1);
    drain();
    check("hold_23", {24'd0, received_data}, 32'h23);

    send_frame(8'h29, 1'b1, 1'b1, 11, -1);
    drain();
    check("keep_after_perr", {24'd0, received_data}, 32'h23);

    send_frame(8'h1C, 1'b0, 1'b0, 11, -1);
    drain();
    check("keep_after_ferr", {24'd0, received_data}, 32'h23);

    send_frame(8'h5A, 1'b0, 1'b1, 5, -1);
    drain();
    check("keep_after_timeout", {24'd0, received_data}, 32'h23);
    send_frame(8'h23, 1'b0, 1'b1, 11, -1);
    drain();

    PS2_CLK = 1'b0;
    wait_cycles(5);
    PS2_CLK = 1'b1;
    wait_cycles(100);
    send_frame(8'h1C, 1'b0, 1'b1, 11, 4);
    drain();
    check("glitch_1C", {24'd0, received_data}, 32'h1C);

    drive_bit(1'b0, 1'b0, 1'b0, K_EN, 8'h00, 0);
    for (int i = 0; i < 4; i++)
      drive_bit(i[0], 1'b0, 1'b0, K_EN, 8'h00, 0);
    @(negedge CLOCK_50);
    Resetn = 1'b0;
    #1;
    check("midrst_data", {24'd0, received_data}, 0);
    check("midrst_en", {31'd0, received_data_en}, 0);
    check("midrst_perr", {31'd0, parity_err}, 0);
    check("midrst_ferr", {31'd0, frame_err}, 0);
    wait_cycles(10);
    Resetn = 1'b1;
    wait_cycles(20);
    send_frame(8'h29, 1'b0, 1'b1, 11, -1);
    drain();
    check("post_rst_29", {24'd0, received_data}, 32'h29);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
